clk_div_ctrl: RTL

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl_pkg.sv | 17 +
 rtl/clk_div_ctrl_div_core.sv | 56 +++++
 rtl/clk_div_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_pkg.sv
// Purpose : shared types and constants for the programmable clock divider.
// Latency : n/a (declarations only).
// Backpres: n/a.
package clk_div_ctrl_pkg;

    // Controller states: stopped, running at o_cur_div, running with a
    // ratio change waiting for the period boundary.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    // Smallest ratio that still yields a high and a low phase.
    localparam int DIV_MIN = 2;

endpackage

// File: rtl/clk_div_ctrl_div_core.sv
// Purpose : period counter and duty compare for the divided clock.
// Latency : level registered; i_load gives a high level on the next cycle.
// Backpres: none; follows i_load / i_run every cycle.
//
// Ports:
//   i_clk, i_rst : clock, async active-high reset
//   i_n          : ratio N of the period currently being generated
//   i_load       : start a new period (count 0, level high) on the next cycle
//   i_run        : advance the count; when low (and no load) the core parks
//   o_bnd        : count is at N-1, the last cycle of the period
//   o_lvl        : registered divided-clock level
module div_core
    import clk_div_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [CNT_W-1:0] i_n,
    input  logic             i_load,
    input  logic             i_run,
    output logic             o_bnd,
    output logic             o_lvl
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_lvl;

    logic [CNT_W-1:0] w_high;
    logic [CNT_W-1:0] w_cnt_inc;

    // High phase gets the extra cycle of an odd ratio.
    assign w_high    = i_n - (i_n >> 1);
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign o_bnd     = (r_cnt == i_n - CNT_W'(1));
    assign o_lvl     = r_lvl;

    // The level is computed from the next count value so that it is
    // registered yet stays aligned with r_cnt.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_lvl <= 1'b0;
        end else if (i_load) begin
            r_cnt <= '0;
            r_lvl <= 1'b1;
        end else if (i_run) begin
            r_cnt <= w_cnt_inc;
            r_lvl <= (w_cnt_inc < w_high);
        end else begin
            r_cnt <= '0;
            r_lvl <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Purpose : glitch-free programmable clock divider with ratio-change handshake.
// Latency : all outputs registered; ack/err/first high level one cycle after request.
// Backpres: o_busy while a change is pending; requests during o_busy are dropped.
//
// Ports:
//   i_clk, i_rst       : clock, async active-high reset
//   i_en               : run level; dropping it stops after the current period
//   i_req, i_div       : ratio-change strobe and requested ratio N
//   o_div_clk, o_tick  : divided clock and its rising-edge pulse
//   o_ack, o_err       : new ratio in effect / invalid request pulses
//   o_busy, o_cur_div  : change pending flag, ratio currently in effect
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_req,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_div_clk,
    output logic             o_tick,
    output logic             o_ack,
    output logic             o_err,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_cur_div
);

    state_t           r_state;
    logic [CNT_W-1:0] r_pend;
    logic [CNT_W-1:0] r_cur_div;
    logic             r_tick;
    logic             r_ack;
    logic             r_err;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_pend_nxt;
    logic [CNT_W-1:0] w_cur_nxt;
    logic             w_ack;
    logic             w_err;
    logic             w_load;
    logic             w_run;
    logic             w_bnd;
    logic             w_lvl;
    logic             w_req_ok;
    logic             w_req_bad;

    assign w_req_ok  = i_req && (i_div >= CNT_W'(DIV_MIN));
    assign w_req_bad = i_req && (i_div <  CNT_W'(DIV_MIN));

    div_core #(.CNT_W(CNT_W)) u_core (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_n    (r_cur_div),
        .i_load (w_load),
        .i_run  (w_run),
        .o_bnd  (w_bnd),
        .o_lvl  (w_lvl)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_pend    <= '0;
            r_cur_div <= '0;
            r_tick    <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend    <= w_pend_nxt;
            r_cur_div <= w_cur_nxt;
            r_tick    <= w_load;
            r_ack     <= w_ack;
            r_err     <= w_err;
            r_busy    <= (w_state_nxt == ST_PEND);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_cur_nxt   = r_cur_div;
        w_ack       = 1'b0;
        w_err       = 1'b0;
        w_load      = 1'b0;
        w_run       = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_req_ok) begin
                    w_cur_nxt = i_div;
                    w_ack     = 1'b1;
                    if (i_en) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end else if (w_req_bad) begin
                    w_err = 1'b1;
                end else if (i_en && (r_cur_div != '0)) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                w_run = 1'b1;
                // A request in the boundary cycle becomes pending and only
                // switches at the next boundary, never mid-period.
                if (w_req_ok) begin
                    w_pend_nxt  = i_div;
                    w_state_nxt = ST_PEND;
                end else if (w_req_bad) begin
                    w_err = 1'b1;
                end
                if (w_bnd) begin
                    if (i_en) begin
                        w_load = 1'b1;
                    end else begin
                        // Stopping: there is no later boundary, so a request
                        // in this cycle is committed right away.
                        w_run       = 1'b0;
                        w_state_nxt = ST_IDLE;
                        if (w_req_ok) begin
                            w_cur_nxt = i_div;
                            w_ack     = 1'b1;
                        end
                    end
                end
            end

            ST_PEND: begin
                w_run = 1'b1;
                if (w_bnd) begin
                    w_cur_nxt = r_pend;
                    w_ack     = 1'b1;
                    if (i_en) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_run       = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_div_clk = w_lvl;
    assign o_tick    = r_tick;
    assign o_ack     = r_ack;
    assign o_err     = r_err;
    assign o_busy    = r_busy;
    assign o_cur_div = r_cur_div;

endmodule
